// File: rtl/id_regfile_if.sv
// ---------------------------------------------------------------------------
// id_regfile_if
//
// Bundles every non-clock signal between the ID/WB pipeline logic and the
// integer register file.
//
// Signal semantics (there is no back-pressure anywhere on this interface):
//   * RegWrite, issue_valid and kill_valid are single-cycle qualifiers. The
//     event they qualify happens exactly once, on the rising clock edge that
//     ends the cycle in which the qualifier is high. The associated address
//     and data fields only have meaning while their qualifier is high.
//   * rs1_data, rs2_data, rs1_busy and rs2_busy are combinational responses
//     to the addresses and writeback inputs presented in the same cycle.
//   * sb_error is registered and sticky until reset.
//
// Modports:
//   master : ID/WB pipeline side, drives addresses, writeback, issue and kill
//   slave  : register file side, drives read data, busy flags and sb_error
// ---------------------------------------------------------------------------
interface id_regfile_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    // read ports
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // writeback port from the WB stage
    logic            RegWrite;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;

    // scoreboard events
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_RegWrite;
    logic            kill_valid;
    logic [AW-1:0]   kill_rd;

    // scoreboard status
    logic            rs1_busy;
    logic            rs2_busy;
    logic            sb_error;

    modport master (
        output rs1_addr, rs2_addr,
        output RegWrite, rd_addr, rd_data,
        output issue_valid, issue_rd, issue_RegWrite,
        output kill_valid, kill_rd,
        input  rs1_data, rs2_data,
        input  rs1_busy, rs2_busy, sb_error
    );

    modport slave (
        input  rs1_addr, rs2_addr,
        input  RegWrite, rd_addr, rd_data,
        input  issue_valid, issue_rd, issue_RegWrite,
        input  kill_valid, kill_rd,
        output rs1_data, rs2_data,
        output rs1_busy, rs2_busy, sb_error
    );
endinterface

// File: rtl/id_regfile.sv
// ---------------------------------------------------------------------------
// id_regfile
//
// Architectural integer register file for the ID stage with a per-register
// in-flight-write scoreboard.
//
//   * Two combinational read ports with write-first bypass: a value retiring
//     from WB in this cycle is visible on the read ports in the same cycle.
//   * x0 is hard-wired to zero; any write, issue or kill aimed at x0 is
//     dropped without touching storage, counters or the error flag.
//   * Each register has a CNT_W-bit counter of outstanding writers:
//     issue increments, retire (RegWrite) and kill decrement. Events on the
//     same register in one cycle are netted before the range check.
//     Underflow clamps to 0, overflow holds at max; both set sb_error,
//     which is sticky until rst.
//   * rsN_busy reports an outstanding writer for rsN that is not retiring
//     this cycle (the retiring one is served by the bypass).
//
// Ports:
//   clk  : rising-edge clock for all state
//   rst  : synchronous, active-high reset; overrides all concurrent events
//   bus  : id_regfile_if.slave carrying read ports, writeback port,
//          issue/kill events, busy flags and sb_error
// ---------------------------------------------------------------------------
module id_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 2
) (
    input  logic         clk,
    input  logic         rst,
    id_regfile_if.slave  bus
);

    localparam int AW = $clog2(NREGS);
    // Two extra bits: one for the +1 headroom, one for the sign.
    localparam int SW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [CNT_W-1:0] cnt_q  [NREGS];
    logic [CNT_W-1:0] cnt_d  [NREGS];
    logic             sb_error_q;

    // ------------------------------------------------------------------
    // Event decode, one bit per register. Bit 0 is never set, so x0
    // never sees any scoreboard activity.
    // ------------------------------------------------------------------
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] ret_vec;
    logic [NREGS-1:0] kil_vec;

    always_comb begin
        inc_vec = '0;
        ret_vec = '0;
        kil_vec = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc_vec[r] = bus.issue_valid && bus.issue_RegWrite &&
                         (bus.issue_rd == AW'(r));
            ret_vec[r] = bus.RegWrite   && (bus.rd_addr == AW'(r));
            kil_vec[r] = bus.kill_valid && (bus.kill_rd == AW'(r));
        end
    end

    // ------------------------------------------------------------------
    // Counter next-state with netting and range check.
    // The sum is formed modulo 2^SW; with at most +1/-2 applied to a
    // value in [0, CNT_MAX] the result is an exact two's complement
    // number, so the top bit flags underflow and any set bit between
    // the sign and the counter field flags overflow.
    // ------------------------------------------------------------------
    logic [SW-1:0] net;
    logic          any_err;

    always_comb begin
        net     = '0;
        any_err = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            net = {2'b00, cnt_q[r]}
                + SW'(inc_vec[r])
                - SW'(ret_vec[r])
                - SW'(kil_vec[r]);
            cnt_d[r] = net[CNT_W-1:0];
            if (net[SW-1]) begin
                cnt_d[r] = '0;
                any_err  = 1'b1;
            end else if (net[SW-2:CNT_W] != '0) begin
                cnt_d[r] = CNT_MAX;
                any_err  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            sb_error_q <= 1'b0;
        end else begin
            if (bus.RegWrite && (bus.rd_addr != '0)) begin
                regs_q[bus.rd_addr] <= bus.rd_data;
            end
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            sb_error_q <= sb_error_q | any_err;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: x0 -> 0, else write-first bypass, else storage.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_comb begin
        rs1_val = regs_q[bus.rs1_addr];
        if (bus.rs1_addr == '0) begin
            rs1_val = '0;
        end else if (bus.RegWrite && (bus.rd_addr == bus.rs1_addr)) begin
            rs1_val = bus.rd_data;
        end
    end

    always_comb begin
        rs2_val = regs_q[bus.rs2_addr];
        if (bus.rs2_addr == '0) begin
            rs2_val = '0;
        end else if (bus.RegWrite && (bus.rd_addr == bus.rs2_addr)) begin
            rs2_val = bus.rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Busy: pre-edge count minus the writer retiring right now. Issue and
    // kill of the current cycle deliberately do not participate.
    // ret_vec[0] is always 0 and cnt_q[0] never leaves 0, so x0 is never
    // busy; the explicit address check keeps that obvious.
    // ------------------------------------------------------------------
    logic [CNT_W:0] rs1_pend;
    logic [CNT_W:0] rs2_pend;
    logic           rs1_busy_c;
    logic           rs2_busy_c;

    always_comb begin
        rs1_pend   = {1'b0, cnt_q[bus.rs1_addr]} - (CNT_W+1)'(ret_vec[bus.rs1_addr]);
        rs2_pend   = {1'b0, cnt_q[bus.rs2_addr]} - (CNT_W+1)'(ret_vec[bus.rs2_addr]);
        rs1_busy_c = (bus.rs1_addr != '0) && !rs1_pend[CNT_W] && (rs1_pend != '0);
        rs2_busy_c = (bus.rs2_addr != '0) && !rs2_pend[CNT_W] && (rs2_pend != '0);
    end

    assign bus.rs1_data = rs1_val;
    assign bus.rs2_data = rs2_val;
    assign bus.rs1_busy = rs1_busy_c;
    assign bus.rs2_busy = rs2_busy_c;
    assign bus.sb_error = sb_error_q;

endmodule

// File: tb/tb_id_regfile.sv
// ---------------------------------------------------------------------------
// tb_id_regfile
//
// Directed bench for id_regfile. The driver applies one cycle of inputs
// shortly after each rising edge and pushes the hand-computed response for
// that cycle into exp_q. The monitor, on the falling edge, pops every entry
// queued for the current cycle and compares it with the DUT outputs.
// Response word layout: {rs1_data, rs2_data, rs1_busy, rs2_busy, sb_error}.
// ---------------------------------------------------------------------------
module tb_id_regfile;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int W    = 2*XLEN + 3;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_regfile_if #(.XLEN(XLEN), .AW(AW)) bus ();

    id_regfile #(.XLEN(XLEN), .NREGS(32), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks   = 0;
    int           failures = 0;

    always @(negedge clk) begin
        logic [W-1:0] exp_w;
        logic [W-1:0] act_w;
        string        nm;
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_w = {bus.rs1_data, bus.rs2_data, bus.rs1_busy, bus.rs2_busy, bus.sb_error};
            checks++;
            if (act_w !== exp_w) begin
                failures++;
                $display("FAIL %s: got rs1=%h rs2=%h b1=%b b2=%b err=%b, want rs1=%h rs2=%h b1=%b b2=%b err=%b",
                         nm, act_w[W-1 -: XLEN], act_w[XLEN+2 : 3], act_w[2], act_w[1], act_w[0],
                         exp_w[W-1 -: XLEN], exp_w[XLEN+2 : 3], exp_w[2], exp_w[1], exp_w[0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic set_idle();
        bus.rs1_addr       = '0;
        bus.rs2_addr       = '0;
        bus.RegWrite       = 1'b0;
        bus.rd_addr        = '0;
        bus.rd_data        = '0;
        bus.issue_valid    = 1'b0;
        bus.issue_rd       = '0;
        bus.issue_RegWrite = 1'b0;
        bus.kill_valid     = 1'b0;
        bus.kill_rd        = '0;
    endtask

    // Start a new cycle: wait for the edge, then return all inputs to idle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic reads(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.RegWrite = 1'b1;
        bus.rd_addr  = a;
        bus.rd_data  = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        bus.issue_valid    = 1'b1;
        bus.issue_RegWrite = 1'b1;
        bus.issue_rd       = a;
    endtask

    task automatic kill(input logic [AW-1:0] a);
        bus.kill_valid = 1'b1;
        bus.kill_rd    = a;
    endtask

    task automatic expect_out(input string nm, input logic [XLEN-1:0] d1,
                              input logic [XLEN-1:0] d2, input logic b1,
                              input logic b2, input logic er);
        exp_q.push_back({d1, d2, b1, b2, er});
        name_q.push_back(nm);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state on every address of both ports.
        for (int i = 0; i < 32; i++) begin
            if (i != 0) next_cycle();
            reads(AW'(i), AW'(31 - i));
            expect_out($sformatf("reset_read_%0d", i), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        end

        // x5: issue, retire with bypass, then read from storage.
        next_cycle(); issue(5); reads(5, 0);
        expect_out("x5_issue", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle(); reads(5, 0);
        expect_out("x5_busy", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        next_cycle(); wb(5, 32'hDEADBEEF); reads(5, 0);
        expect_out("x5_wb_bypass", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle(); reads(5, 0);
        expect_out("x5_stored", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b0);

        // x0 write is ignored (no storage, no bypass, no error).
        next_cycle(); wb(0, 32'h1234); reads(0, 5);
        expect_out("x0_write_bypass", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        next_cycle(); reads(0, 0);
        expect_out("x0_after_write", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Same-cycle bypass on both ports.
        next_cycle(); issue(7);
        next_cycle(); wb(7, 32'hA5A5A5A5); reads(7, 7);
        expect_out("x7_dual_bypass", 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        next_cycle(); reads(7, 5);
        expect_out("x7_stored", 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);

        // x3: two in-flight writers retiring one at a time.
        next_cycle(); issue(3); reads(3, 0);
        expect_out("x3_issue1", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle(); issue(3); reads(3, 0);
        expect_out("x3_issue2", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        next_cycle(); reads(3, 0);
        expect_out("x3_cnt2", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        next_cycle(); wb(3, 32'h11111111); reads(3, 0);
        expect_out("x3_ret1", 32'h11111111, 32'h0, 1'b1, 1'b0, 1'b0);
        next_cycle(); reads(3, 0);
        expect_out("x3_cnt1", 32'h11111111, 32'h0, 1'b1, 1'b0, 1'b0);
        next_cycle(); wb(3, 32'h22222222); reads(3, 0);
        expect_out("x3_ret2_bypass", 32'h22222222, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle(); reads(3, 0);
        expect_out("x3_cnt0", 32'h22222222, 32'h0, 1'b0, 1'b0, 1'b0);

        // x9: simultaneous issue and retire nets out; kill clears.
        next_cycle(); issue(9); reads(0, 9);
        expect_out("x9_issue", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle(); issue(9); wb(9, 32'h00000099); reads(0, 9);
        expect_out("x9_issue_ret", 32'h0, 32'h00000099, 1'b0, 1'b0, 1'b0);
        next_cycle(); reads(0, 9);
        expect_out("x9_still_busy", 32'h0, 32'h00000099, 1'b0, 1'b1, 1'b0);
        next_cycle(); kill(9); reads(0, 9);
        expect_out("x9_kill_cycle", 32'h0, 32'h00000099, 1'b0, 1'b1, 1'b0);
        next_cycle(); reads(0, 9);
        expect_out("x9_after_kill", 32'h0, 32'h00000099, 1'b0, 1'b0, 1'b0);

        // x4: underflow then overflow, counter must saturate at 3.
        next_cycle(); wb(4, 32'h00000044); reads(4, 0);
        expect_out("x4_underflow_cycle", 32'h00000044, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle(); reads(4, 0);
        expect_out("x4_err_set", 32'h00000044, 32'h0, 1'b0, 1'b0, 1'b1);
        next_cycle(); issue(4); reads(4, 0);
        expect_out("x4_issue1", 32'h00000044, 32'h0, 1'b0, 1'b0, 1'b1);
        next_cycle(); issue(4); reads(4, 0);
        expect_out("x4_issue2", 32'h00000044, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle(); issue(4); reads(4, 0);
        expect_out("x4_issue3", 32'h00000044, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle(); issue(4); reads(4, 0);
        expect_out("x4_issue4_ovf", 32'h00000044, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle(); reads(4, 0);
        expect_out("x4_sat", 32'h00000044, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle(); wb(4, 32'h00000045); reads(4, 0);
        expect_out("x4_drain1", 32'h00000045, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle(); wb(4, 32'h00000046); reads(4, 0);
        expect_out("x4_drain2", 32'h00000046, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle(); wb(4, 32'h00000047); reads(4, 0);
        expect_out("x4_drain3", 32'h00000047, 32'h0, 1'b0, 1'b0, 1'b1);
        next_cycle(); reads(4, 0);
        expect_out("x4_empty", 32'h00000047, 32'h0, 1'b0, 1'b0, 1'b1);

        // x10: retire and kill together subtract 2.
        next_cycle(); issue(10);
        next_cycle(); issue(10);
        next_cycle(); reads(10, 0);
        expect_out("x10_cnt2", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle(); wb(10, 32'h000000A0); kill(10); reads(10, 0);
        expect_out("x10_ret_kill", 32'h000000A0, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle(); reads(10, 0);
        expect_out("x10_cnt0", 32'h000000A0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Mid-operation reset clears storage, counters and sb_error, and
        // wins over an issue in the same cycle.
        next_cycle(); issue(11);
        next_cycle(); reads(11, 0);
        expect_out("x11_busy", 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        next_cycle(); rst = 1'b1; issue(12); wb(5, 32'hFFFFFFFF);
        next_cycle(); rst = 1'b0; reads(11, 12);
        expect_out("post_rst_busy", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        next_cycle(); reads(5, 3);
        expect_out("post_rst_data", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Let the monitor drain the last entry.
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_regfile.md
Name: id_regfile

Overview:
Architectural integer register file in the ID stage. It is the consumer of the writeback port (rd_addr / rd_data / RegWrite) driven by the WB stage. It provides two combinational read ports with write-first bypass, so ID sees a value retiring in WB in the same cycle. It also holds a per-register in-flight-write scoreboard; ID uses the busy flags to stall on RAW hazards that cannot be forwarded.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (x0..x31); address width is clog2(NREGS)
CNT_W, 2, width of each scoreboard counter; max in-flight writes per register = 2^CNT_W-1

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
rs1_addr  input  5  read port 1 address
rs2_addr  input  5  read port 2 address
rs1_data  output  XLEN  read port 1 data (combinational)
rs2_data  output  XLEN  read port 2 data (combinational)
RegWrite  input  1  writeback enable from WB stage
rd_addr  input  5  writeback destination from WB stage
rd_data  input  XLEN  writeback data from WB stage
issue_valid  input  1  ID hands an instruction to EX this cycle
issue_rd  input  5  destination of the issued instruction
issue_RegWrite  input  1  issued instruction will write rd
kill_valid  input  1  an issued, not-yet-retired writer is squashed this cycle
kill_rd  input  5  destination of the squashed writer
rs1_busy  output  1  rs1 has an outstanding writer not retiring this cycle
rs2_busy  output  1  rs2 has an outstanding writer not retiring this cycle
sb_error  output  1  sticky scoreboard over/underflow flag

Behaviour:
- Reset (rst=1 at clk edge): all registers cleared to 0, all counters to 0, sb_error to 0. Outputs after reset: rs*_data=0, rs*_busy=0, sb_error=0. Reset overrides every concurrent write, issue and kill.
- x0: reads always return 0 and x0 is never busy. Writes, issues and kills targeting x0 are ignored: no storage update, no counter change, no error.
- Write: if RegWrite && rd_addr!=0, reg[rd_addr] <= rd_data at the edge.
- Read: rsN_data = 0 if rsN_addr==0. Otherwise, if RegWrite && rd_addr==rsN_addr, it equals rd_data (write-first bypass, zero latency). Otherwise it is reg[rsN_addr].
- Scoreboard events per cycle, each applying only when its target is nonzero:
  - inc: issue_valid && issue_RegWrite (target issue_rd)
  - ret: RegWrite (target rd_addr)
  - kil: kill_valid (target kill_rd)
- Counter update: cnt[r] <= cnt[r] + inc(r) - ret(r) - kil(r), computed in CNT_W+2 signed bits. Events for the same r in the same cycle net out; inc and ret together on the same r leaves the counter unchanged.
- Underflow: the net result is < 0. The counter is clamped to 0 and sb_error is set.
- Overflow: the net result is > 2^CNT_W-1. The counter is held at max and sb_error is set.
- sb_error stays set until rst.
- Busy: rsN_busy = (rsN_addr!=0) && (cnt[rsN_addr] - ret(rsN_addr) > 0). It is combinational and uses the pre-edge counter. A writer retiring this cycle is covered by the bypass and does not stall. The issue and kill inputs of the current cycle do not affect busy.
- ret and kil on the same register in the same cycle are legal and decrement by 2.
- Mid-operation reset discards all outstanding scoreboard state. The pipeline is reset in the same cycle.

Test Plan:
- Reset, then read all 32 addresses -> every rs*_data=0, rs*_busy=0, sb_error=0.
- Write x5=0xDEADBEEF; next cycle read rs1=x5, rs2=x0 -> rs1_data=0xDEADBEEF, rs2_data=0. Write x0=0x1234 -> x0 still reads 0.
- Same-cycle bypass: RegWrite=1, rd_addr=7, rd_data=0xA5A5A5A5, rs1_addr=rs2_addr=7 -> both read 0xA5A5A5A5 that cycle.
- Scoreboard: issue x3 twice on consecutive cycles -> rs1_busy (rs1=x3) is 1. Retire x3 once -> still busy. On the cycle of the second retire -> busy=0, and data comes from bypass. Afterwards the counter is 0.
- Simultaneous issue and retire of x9 with cnt=1 -> cnt stays 1 and busy stays 1 on the next cycle. Then kill x9 -> cnt=0, busy=0.
- Errors: retire x4 with cnt=0 -> sb_error=1 next cycle and cnt stays 0. Issue x4 four times with CNT_W=2 -> cnt=3 and sb_error stays set. rst -> sb_error=0.
